mem_stage_hs: RTL and testbench
===============================

// Module: mem_stage_hs
// PURPOSE
//  Parametrised memory pipeline stage with a req/ack data-memory handshake.
//  Sits between execute and writeback. Non-memory ops pass through in one cycle.
//  Loads/stores hold the stage in a WAIT state until memory acknowledges, and
//  stall upstream meanwhile. Adds reset, flush, variable memory latency and
//  parametrised widths. Bubble/halt propagation is unchanged.
// PARAMETERS
//  DATA_W  16       datapath width (result, store data, read data)
//  ADDR_W  16       memory address width; address = result_in[ADDR_W-1:0], ADDR_W<=DATA_W
//  TGT_W   3        register target index width
//  OP_W    3        opcode width
//  LD_OP   3'd4     opcode value of a load
//  ST_OP   3'd5     opcode value of a store
// PORTS
//  clk            in   1       clock; all state on posedge
//  rst            in   1       asynchronous, active-high reset
//  halt           in   1       global freeze; when 1 no state changes
//  flush          in   1       kill incoming instruction (sync, see rules)
//  bubble_in      in   1       incoming slot is a bubble
//  opcode_in      in   OP_W    incoming opcode
//  tgt_in         in   TGT_W   incoming writeback target
//  result_in      in   DATA_W  ALU result / memory address
//  store_data_in  in   DATA_W  store data
//  halt_in        in   1       incoming instruction is a halt
//  stall_out      out  1       upstream must hold its inputs (combinational)
//  mem_req        out  1       memory request valid
//  mem_we         out  1       1=store, 0=load
//  mem_addr       out  ADDR_W  request address
//  mem_wdata      out  DATA_W  store data
//  mem_ack        in   1       request complete; mem_rdata valid when 1
//  mem_rdata      in   DATA_W  load data
//  tgt_out        out  TGT_W   writeback target
//  opcode_out     out  OP_W    opcode to writeback
//  result_out     out  DATA_W  result or load data
//  bubble_out     out  1       output slot is a bubble
//  halt_out       out  1       halt has reached this stage
// BEHAVIOUR
//  Reset (async, any time): state=IDLE. bubble_out=1, halt_out=0.
//    mem_req=0, mem_we=0. All data/target/opcode/address outputs = 0.
//    An in-flight request is abandoned; memory must tolerate req dropping.
//  halt=1: all registers frozen, including FSM and mem_req; mem_ack is ignored.
//    Memory holds mem_ack/mem_rdata until sampled on a halt=0 edge.
//  valid = !bubble_in && !halt_out && !flush. is_mem = opcode_in==LD_OP or ST_OP.
//  IDLE, !(valid && is_mem): one-cycle pass, matching the existing stage:
//    tgt/opcode/result_out <= inputs.
//    bubble_out <= (halt_out|flush) ? 1 : bubble_in.
//    halt_out <= halt_in && !bubble_in && !flush.
//  IDLE, valid && is_mem: stall_out=1 combinationally. On the edge:
//    mem_req<=1, mem_we<=(op==ST_OP), mem_addr<=result_in[ADDR_W-1:0],
//    mem_wdata<=store_data_in. Latch opcode/tgt. bubble_out<=1. State -> WAIT.
//  WAIT: mem_req, mem_addr, mem_we and mem_wdata are held stable.
//    stall_out = !mem_ack. bubble_out stays 1 while mem_ack=0.
//  WAIT with mem_ack=1: stall_out=0 and state -> IDLE on the edge. Also on that edge:
//    mem_req<=0, bubble_out<=0, opcode_out<=latched opcode.
//    Load: result_out<=mem_rdata, tgt_out<=latched tgt.
//    Store: tgt_out<=0 (no writeback), result_out<=address zero-extended.
//    Upstream advances on the same edge.
//  mem_ack while IDLE is ignored. Minimum memory-op latency is 2 edges
//    (issue edge, ack edge); ack may arrive the cycle after req.
//  flush in WAIT: no effect. A committed memory op always completes.
//  flush in IDLE: the incoming slot becomes a bubble and no request is issued.
//  Back-to-back memory ops: after the ack edge, the next op issues on the
//    following edge. mem_req stays 0 for at least one cycle between requests.
//  Once halt_out=1, all later inputs are treated as bubbles; no new requests.
// TESTING
//  1 rst pulse mid-WAIT (mem_req=1) -> mem_req=0, bubble_out=1 immediately; state IDLE.
//  2 ALU op result_in=16'h1234, tgt_in=3 -> next edge result_out=16'h1234, tgt_out=3, bubble_out=0.
//  3 load addr 16'h0040, mem_ack after 3 cycles with rdata=16'hBEEF -> stall_out=1 for 4 cycles;
//      bubble_out=1 throughout; then result_out=16'hBEEF, tgt_out=latched, bubble_out=0.
//  4 store addr 16'h0010, data 16'h00AA, ack next cycle -> mem_we=1, mem_wdata=16'h00AA; tgt_out=0.
//  5 halt=1 for 5 cycles while WAIT with mem_ack=1 -> no state change; completes on the first halt=0 edge.
//  6 flush with load in IDLE -> mem_req stays 0, bubble_out=1. Flush in WAIT -> load still completes.
//      halt_in on a non-bubble -> halt_out=1; a following load never raises mem_req.

Source files
------------

// File: rtl/mem_stage_hs.sv
// Memory pipeline stage between execute and writeback with a req/ack data-memory handshake.
// Latency: non-memory ops 1 cycle; loads/stores 2+ edges (issue edge, then ack edge).
// Backpressure: stall_out holds upstream while a memory op is issuing or waiting for mem_ack.
//
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   halt                         global freeze; no register changes while 1
//   flush                        kills the incoming slot (ignored once a request is committed)
//   bubble_in/opcode_in/tgt_in/
//   result_in/store_data_in/
//   halt_in                      incoming instruction from execute
//   stall_out                    combinational upstream hold
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_ack/mem_rdata  data-memory handshake
//   tgt_out/opcode_out/
//   result_out/bubble_out/
//   halt_out                     registered slot to writeback
module mem_stage_hs #(
    parameter int              DATA_W = 16,
    parameter int              ADDR_W = 16,
    parameter int              TGT_W  = 3,
    parameter int              OP_W   = 3,
    parameter logic [OP_W-1:0] LD_OP  = OP_W'(4),
    parameter logic [OP_W-1:0] ST_OP  = OP_W'(5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              flush,
    input  logic              bubble_in,
    input  logic [OP_W-1:0]   opcode_in,
    input  logic [TGT_W-1:0]  tgt_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic              halt_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [TGT_W-1:0]  tgt_out,
    output logic [OP_W-1:0]   opcode_out,
    output logic [DATA_W-1:0] result_out,
    output logic              bubble_out,
    output logic              halt_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [OP_W-1:0]   r_op;
    logic [TGT_W-1:0]  r_tgt;
    logic [TGT_W-1:0]  r_tgt_out;
    logic [OP_W-1:0]   r_opcode_out;
    logic [DATA_W-1:0] r_result_out;
    logic              r_bubble_out;
    logic              r_halt_out;

    logic              w_valid;
    logic              w_is_mem;
    logic              w_issue;
    logic [DATA_W-1:0] w_addr_ext;

    // A halt that has reached writeback turns every later slot into a bubble.
    assign w_valid    = !bubble_in && !r_halt_out && !flush;
    assign w_is_mem   = (opcode_in == LD_OP) || (opcode_in == ST_OP);
    assign w_issue    = (r_state == S_IDLE) && w_valid && w_is_mem;
    assign w_addr_ext = DATA_W'(r_mem_addr);

    // Issue cycle stalls unconditionally; while waiting, upstream may move on the ack edge.
    assign stall_out  = (r_state == S_IDLE) ? w_issue : !mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_op         <= '0;
            r_tgt        <= '0;
            r_tgt_out    <= '0;
            r_opcode_out <= '0;
            r_result_out <= '0;
            r_bubble_out <= 1'b1;
            r_halt_out   <= 1'b0;
        end else if (!halt) begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= (opcode_in == ST_OP);
                        r_mem_addr   <= result_in[ADDR_W-1:0];
                        r_mem_wdata  <= store_data_in;
                        r_op         <= opcode_in;
                        r_tgt        <= tgt_in;
                        r_bubble_out <= 1'b1;
                        r_state      <= S_WAIT;
                    end else begin
                        r_tgt_out    <= tgt_in;
                        r_opcode_out <= opcode_in;
                        r_result_out <= result_in;
                        r_bubble_out <= (r_halt_out || flush) ? 1'b1 : bubble_in;
                        // Sticky so nothing after the halt can ever issue a request.
                        r_halt_out   <= r_halt_out || (halt_in && !bubble_in && !flush);
                    end
                end
                S_WAIT: begin
                    // flush is deliberately ignored here: a committed access always completes.
                    if (mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_bubble_out <= 1'b0;
                        r_opcode_out <= r_op;
                        r_state      <= S_IDLE;
                        if (r_mem_we) begin
                            r_tgt_out    <= '0;
                            r_result_out <= w_addr_ext;
                        end else begin
                            r_tgt_out    <= r_tgt;
                            r_result_out <= mem_rdata;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign tgt_out    = r_tgt_out;
    assign opcode_out = r_opcode_out;
    assign result_out = r_result_out;
    assign bubble_out = r_bubble_out;
    assign halt_out   = r_halt_out;

endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;

    localparam logic [2:0] LD = 3'd4;
    localparam logic [2:0] ST = 3'd5;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        flush;
    logic        bubble_in;
    logic [2:0]  opcode_in;
    logic [2:0]  tgt_in;
    logic [15:0] result_in;
    logic [15:0] store_data_in;
    logic        halt_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [2:0]  tgt_out;
    logic [2:0]  opcode_out;
    logic [15:0] result_out;
    logic        bubble_out;
    logic        halt_out;

    mem_stage_hs dut (
        .clk(clk), .rst(rst), .halt(halt), .flush(flush),
        .bubble_in(bubble_in), .opcode_in(opcode_in), .tgt_in(tgt_in),
        .result_in(result_in), .store_data_in(store_data_in), .halt_in(halt_in),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .tgt_out(tgt_out), .opcode_out(opcode_out),
        .result_out(result_out), .bubble_out(bubble_out), .halt_out(halt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        bub;
        logic [2:0]  tgt;
        logic [2:0]  op;
        logic [15:0] res;
        logic        hlt;
    } out_t;

    typedef struct {
        logic        bub;
        logic [2:0]  op;
        logic [2:0]  tgt;
        logic [15:0] res;
        logic [15:0] sd;
        logic        hin;
        logic        fl;
        out_t        exp;
    } vec_t;

    out_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic out_t mk(input logic b, input logic [2:0] t, input logic [2:0] o,
                                input logic [15:0] r, input logic h);
        out_t x;
        x.bub = b; x.tgt = t; x.op = o; x.res = r; x.hlt = h;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm);
        out_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got output %0h expected an entry", nm, result_out);
        end else begin
            e = sb.pop_front();
            chk({nm, ".bubble"}, 32'(bubble_out), 32'(e.bub));
            chk({nm, ".tgt"},    32'(tgt_out),    32'(e.tgt));
            chk({nm, ".op"},     32'(opcode_out), 32'(e.op));
            chk({nm, ".result"}, 32'(result_out), 32'(e.res));
            chk({nm, ".halt"},   32'(halt_out),   32'(e.hlt));
        end
    endtask

    task automatic drive(input logic b, input logic [2:0] o, input logic [2:0] t,
                         input logic [15:0] r, input logic [15:0] sd,
                         input logic hin, input logic fl);
        bubble_in = b; opcode_in = o; tgt_in = t; result_in = r;
        store_data_in = sd; halt_in = hin; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One memory access: issue, dly cycles without ack, then the ack cycle.
    task automatic do_mem(input string nm, input logic [2:0] op, input logic [2:0] tgt,
                          input logic [15:0] addr, input logic [15:0] wd, input int dly,
                          input logic [15:0] rd, input logic fl_wait);
        int stalls;
        stalls = 0;
        mem_ack = 1'b0;
        drive(1'b0, op, tgt, addr, wd, 1'b0, 1'b0);
        if (op == LD) sb.push_back(mk(1'b0, tgt, op, rd, 1'b0));
        else          sb.push_back(mk(1'b0, 3'd0, op, addr, 1'b0));
        #1;
        if (stall_out) stalls++;
        step();
        chk({nm, ".req"},   32'(mem_req),    32'd1);
        chk({nm, ".we"},    32'(mem_we),     32'(op == ST));
        chk({nm, ".addr"},  32'(mem_addr),   32'(addr));
        chk({nm, ".bub_i"}, 32'(bubble_out), 32'd1);
        if (op == ST) chk({nm, ".wdata"}, 32'(mem_wdata), 32'(wd));
        for (int k = 0; k < dly; k++) begin
            flush = fl_wait;
            #1;
            if (stall_out) stalls++;
            step();
            chk({nm, ".req_w"}, 32'(mem_req),    32'd1);
            chk({nm, ".bub_w"}, 32'(bubble_out), 32'd1);
        end
        mem_ack = 1'b1;
        mem_rdata = rd;
        #1;
        chk({nm, ".stall_ack"}, 32'(stall_out), 32'd0);
        step();
        mem_ack = 1'b0;
        flush = 1'b0;
        chk({nm, ".stalls"}, 32'(stalls), 32'(1 + dly));
        chk({nm, ".req_done"}, 32'(mem_req), 32'd0);
        check_out(nm);
    endtask

    vec_t vt[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; halt = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        drive(1'b1, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.bubble", 32'(bubble_out), 32'd1);
        chk("rst.halt",   32'(halt_out),   32'd0);
        chk("rst.req",    32'(mem_req),    32'd0);
        chk("rst.we",     32'(mem_we),     32'd0);
        chk("rst.result", 32'(result_out), 32'd0);
        chk("rst.addr",   32'(mem_addr),   32'd0);
        rst = 1'b0;

        //          bub  op    tgt   res       sd       hin   fl    expected
        vt[0] = '{1'b0, 3'd1, 3'd3, 16'h1234, 16'h0, 1'b0, 1'b0, mk(1'b0, 3'd3, 3'd1, 16'h1234, 1'b0)};
        vt[1] = '{1'b1, 3'd2, 3'd5, 16'h5555, 16'h0, 1'b0, 1'b0, mk(1'b1, 3'd5, 3'd2, 16'h5555, 1'b0)};
        vt[2] = '{1'b0, 3'd1, 3'd2, 16'h0F0F, 16'h0, 1'b0, 1'b1, mk(1'b1, 3'd2, 3'd1, 16'h0F0F, 1'b0)};
        vt[3] = '{1'b0, LD,   3'd6, 16'h0040, 16'h0, 1'b0, 1'b1, mk(1'b1, 3'd6, LD,   16'h0040, 1'b0)};
        vt[4] = '{1'b1, LD,   3'd1, 16'h0044, 16'h0, 1'b0, 1'b0, mk(1'b1, 3'd1, LD,   16'h0044, 1'b0)};
        vt[5] = '{1'b0, 3'd7, 3'd7, 16'hFFFF, 16'h0, 1'b0, 1'b0, mk(1'b0, 3'd7, 3'd7, 16'hFFFF, 1'b0)};
        vt[6] = '{1'b1, 3'd0, 3'd0, 16'h0000, 16'h0, 1'b1, 1'b0, mk(1'b1, 3'd0, 3'd0, 16'h0000, 1'b0)};
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].bub, vt[i].op, vt[i].tgt, vt[i].res, vt[i].sd, vt[i].hin, vt[i].fl);
            sb.push_back(vt[i].exp);
            #1;
            chk($sformatf("vec%0d.stall", i), 32'(stall_out), 32'd0);
            step();
            chk($sformatf("vec%0d.req", i), 32'(mem_req), 32'd0);
            check_out($sformatf("vec%0d", i));
        end

        // Load with three waiting cycles, then store acked next cycle, back to back.
        do_mem("load", LD, 3'd4, 16'h0040, 16'h0000, 3, 16'hBEEF, 1'b0);
        do_mem("store", ST, 3'd6, 16'h0010, 16'h00AA, 0, 16'h0000, 1'b0);
        do_mem("load2", LD, 3'd1, 16'h0ABC, 16'h0000, 1, 16'h1357, 1'b0);
        // Flush while waiting must not kill the committed load.
        do_mem("flushwait", LD, 3'd2, 16'h0020, 16'h0000, 2, 16'h5A5A, 1'b1);
        drive(1'b1, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();

        // Halt freeze while ack is pending.
        drive(1'b0, LD, 3'd5, 16'h0030, 16'h0, 1'b0, 1'b0);
        sb.push_back(mk(1'b0, 3'd5, LD, 16'hCAFE, 1'b0));
        step();
        halt = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("halt.req", 32'(mem_req), 32'd1);
            chk("halt.bub", 32'(bubble_out), 32'd1);
        end
        halt = 1'b0;
        step();
        mem_ack = 1'b0;
        chk("halt.req_done", 32'(mem_req), 32'd0);
        check_out("halt");

        // Reset in the middle of a wait abandons the request immediately.
        drive(1'b0, LD, 3'd3, 16'h0050, 16'h0, 1'b0, 1'b0);
        step();
        chk("rstw.req_pre", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstw.req", 32'(mem_req), 32'd0);
        chk("rstw.bub", 32'(bubble_out), 32'd1);
        drive(1'b1, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        step();
        // Back in IDLE: ALU op passes and a stray ack is ignored.
        drive(1'b0, 3'd2, 3'd3, 16'h4321, 16'h0, 1'b0, 1'b0);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        sb.push_back(mk(1'b0, 3'd3, 3'd2, 16'h4321, 1'b0));
        #1;
        chk("rstw.stall", 32'(stall_out), 32'd0);
        step();
        mem_ack = 1'b0;
        check_out("rstw_alu");

        // Halt instruction then loads: no request may ever issue.
        drive(1'b0, 3'd1, 3'd1, 16'h0009, 16'h0, 1'b1, 1'b0);
        sb.push_back(mk(1'b0, 3'd1, 3'd1, 16'h0009, 1'b1));
        step();
        check_out("haltin");
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, LD, 3'd2, 16'h0080, 16'h0, 1'b0, 1'b0);
            #1;
            chk("postH.stall", 32'(stall_out), 32'd0);
            step();
            chk("postH.req",  32'(mem_req),    32'd0);
            chk("postH.bub",  32'(bubble_out), 32'd1);
            chk("postH.halt", 32'(halt_out),   32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
